// File: rtl/core_wb_arbiter.sv
// Purpose: N-master round-robin arbiter onto one Wishbone peripheral port, with ack timeout returning err.
// Latency: one cycle to arbitrate and register the grant; once granted, the master/slave paths are combinational (0 cycles).
// Backpressure: non-owners see no ack/err and stall; the owner keeps the bus until it drops cyc; a dead slave raises err.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   m_wb_*_i / m_wb_*_o per-master Wishbone request side (flattened buses, master k at slice k)
//   s_wb_*_o / s_wb_*_i shared Wishbone slave side
//   grant_valid_o       a master currently owns the bus
//   grant_idx_o         index of the owning master
module core_wb_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_LEN       = 32,
   parameter int WB_DATA_LEN    = 64,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MASTER_IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_MASTERS-1:0]                 m_wb_cyc_i,
   input  logic [NUM_MASTERS-1:0]                 m_wb_stb_i,
   input  logic [NUM_MASTERS-1:0]                 m_wb_we_i,
   input  logic [NUM_MASTERS*ADDR_LEN-1:0]        m_wb_adr_i,
   input  logic [NUM_MASTERS*WB_DATA_LEN-1:0]     m_wb_dat_i,
   input  logic [NUM_MASTERS*(WB_DATA_LEN/8)-1:0] m_wb_sel_i,
   output logic [NUM_MASTERS-1:0]                 m_wb_ack_o,
   output logic [NUM_MASTERS-1:0]                 m_wb_err_o,
   output logic [WB_DATA_LEN-1:0]                 m_wb_dat_o,
   output logic                                   s_wb_cyc_o,
   output logic                                   s_wb_stb_o,
   output logic                                   s_wb_we_o,
   output logic [ADDR_LEN-1:0]                    s_wb_adr_o,
   output logic [WB_DATA_LEN-1:0]                 s_wb_dat_o,
   output logic [WB_DATA_LEN/8-1:0]               s_wb_sel_o,
   input  logic                                   s_wb_ack_i,
   input  logic [WB_DATA_LEN-1:0]                 s_wb_dat_i,
   output logic                                   grant_valid_o,
   output logic [MASTER_IDX_W-1:0]                grant_idx_o
);

   localparam int SEL_W = WB_DATA_LEN / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [MASTER_IDX_W-1:0] grant_q, grant_d;
   logic [MASTER_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [MASTER_IDX_W-1:0] rr_next;
   logic [31:0]             tmo_cnt_q, tmo_cnt_d;
   logic                    err_q, err_d;
   logic                    stb_q;

   logic [ADDR_LEN-1:0]     adr_arr [NUM_MASTERS];
   logic [WB_DATA_LEN-1:0]  dat_arr [NUM_MASTERS];
   logic [SEL_W-1:0]        sel_arr [NUM_MASTERS];

   logic                    own_cyc, own_stb;
   logic                    pick_vld;
   logic [MASTER_IDX_W-1:0] pick_idx;
   logic [MASTER_IDX_W-1:0] cand;

   always_comb begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
         adr_arr[k] = m_wb_adr_i[k*ADDR_LEN +: ADDR_LEN];
         dat_arr[k] = m_wb_dat_i[k*WB_DATA_LEN +: WB_DATA_LEN];
         sel_arr[k] = m_wb_sel_i[k*SEL_W +: SEL_W];
      end
   end

   assign own_cyc = m_wb_cyc_i[grant_q];
   assign own_stb = m_wb_cyc_i[grant_q] & m_wb_stb_i[grant_q];
   assign rr_next = MASTER_IDX_W'((int'(grant_q) + 1) % NUM_MASTERS);

   // Walk offsets from the far end down to 0 so the requester closest to
   // rr_ptr (offset 0 first) is the last assignment and therefore wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         cand = MASTER_IDX_W'((int'(rr_ptr_q) + i) % NUM_MASTERS);
         if (m_wb_cyc_i[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      tmo_cnt_d = '0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = OWN;
               grant_d = pick_idx;
            end
         end
         OWN: begin
            if (!own_cyc) begin
               state_d  = IDLE;
               rr_ptr_d = rr_next;
            end else if (own_stb && !s_wb_ack_i && (TIMEOUT_CYCLES != 0)) begin
               // The count includes the current unacked cycle; an ack in
               // this same cycle takes the other branch, so ack wins a race.
               if (tmo_cnt_q + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 32'd1;
               end
            end
         end
         ERR: begin
            if (!own_cyc) begin
               state_d  = IDLE;
               rr_ptr_d = rr_next;
            end else if (own_stb && !stb_q) begin
               // Each new strobe from the stranded owner earns its own err.
               err_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
         stb_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
         stb_q     <= own_stb;
      end
   end

   assign grant_valid_o = (state_q != IDLE);
   assign grant_idx_o   = grant_q;

   always_comb begin
      s_wb_cyc_o = 1'b0;
      s_wb_stb_o = 1'b0;
      s_wb_we_o  = 1'b0;
      s_wb_adr_o = '0;
      s_wb_dat_o = '0;
      s_wb_sel_o = '0;
      m_wb_ack_o = '0;
      m_wb_err_o = '0;
      m_wb_dat_o = '0;
      if (state_q == OWN) begin
         s_wb_cyc_o          = own_cyc;
         s_wb_stb_o          = m_wb_stb_i[grant_q];
         s_wb_we_o           = m_wb_we_i[grant_q];
         s_wb_adr_o          = adr_arr[grant_q];
         s_wb_dat_o          = dat_arr[grant_q];
         s_wb_sel_o          = sel_arr[grant_q];
         m_wb_ack_o[grant_q] = s_wb_ack_i;
         m_wb_dat_o          = s_wb_dat_i;
      end else if (state_q == ERR) begin
         m_wb_err_o[grant_q] = err_q;
      end
   end

endmodule

// File: tb/tb_core_wb_arbiter.sv
module tb_core_wb_arbiter;

   localparam int NM  = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int SW  = DW / 8;
   localparam int TMO = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NM-1:0]     m_wb_cyc_i, m_wb_stb_i, m_wb_we_i;
   logic [NM*AW-1:0]  m_wb_adr_i;
   logic [NM*DW-1:0]  m_wb_dat_i;
   logic [NM*SW-1:0]  m_wb_sel_i;
   logic [NM-1:0]     m_wb_ack_o, m_wb_err_o;
   logic [DW-1:0]     m_wb_dat_o;
   logic              s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
   logic [AW-1:0]     s_wb_adr_o;
   logic [DW-1:0]     s_wb_dat_o;
   logic [SW-1:0]     s_wb_sel_o;
   logic              s_wb_ack_i;
   logic [DW-1:0]     s_wb_dat_i;
   logic              grant_valid_o;
   logic [1:0]        grant_idx_o;

   int vectors     = 0;
   int miscompares = 0;

   core_wb_arbiter #(
      .NUM_MASTERS(NM), .ADDR_LEN(AW), .WB_DATA_LEN(DW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .m_wb_cyc_i(m_wb_cyc_i), .m_wb_stb_i(m_wb_stb_i), .m_wb_we_i(m_wb_we_i),
      .m_wb_adr_i(m_wb_adr_i), .m_wb_dat_i(m_wb_dat_i), .m_wb_sel_i(m_wb_sel_i),
      .m_wb_ack_o(m_wb_ack_o), .m_wb_err_o(m_wb_err_o), .m_wb_dat_o(m_wb_dat_o),
      .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
      .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_o(s_wb_sel_o),
      .s_wb_ack_i(s_wb_ack_i), .s_wb_dat_i(s_wb_dat_i),
      .grant_valid_o(grant_valid_o), .grant_idx_o(grant_idx_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
      m_wb_cyc_i[k]          = cyc;
      m_wb_stb_i[k]          = stb;
      m_wb_we_i[k]           = we;
      m_wb_adr_i[k*AW +: AW] = adr;
      m_wb_dat_i[k*DW +: DW] = dat;
      m_wb_sel_i[k*SW +: SW] = sel;
   endtask

   task automatic clear_inputs();
      m_wb_cyc_i = '0; m_wb_stb_i = '0; m_wb_we_i = '0;
      m_wb_adr_i = '0; m_wb_dat_i = '0; m_wb_sel_i = '0;
      s_wb_ack_i = 1'b0; s_wb_dat_i = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Reference: the next grant goes to the first master with outstanding
   // work, searching upward (with wrap) from the master after the last grant.
   task automatic run_random(input int w0, input int w1, input int w2, input int w3, input string tag);
      int              work [NM];
      int              init [NM];
      int              gcount [NM];
      logic [AW-1:0]   mad [NM];
      logic [DW-1:0]   mdt [NM];
      logic [SW-1:0]   msel [NM];
      logic            mwe [NM];
      logic [NM-1:0]   req;
      int              cool [NM];
      int              exp_ptr, owner, total, done, budget, exp_g, slv_cnt, slv_dly;
      logic            slv_act, ack_now, gv_prev;
      logic [DW-1:0]   rd;
      logic [NM-1:0]   onehot;
      work[0] = w0; work[1] = w1; work[2] = w2; work[3] = w3;
      total = 0;
      for (int k = 0; k < NM; k++) begin
         init[k] = work[k]; gcount[k] = 0; cool[k] = 0; total += work[k];
         req[k] = (work[k] > 0);
         mad[k] = $urandom; mdt[k] = {$urandom, $urandom}; msel[k] = SW'($urandom); mwe[k] = 1'($urandom);
      end
      exp_ptr = 0; owner = 0; done = 0; budget = 3000;
      slv_act = 1'b0; slv_cnt = 0; slv_dly = 1; gv_prev = 1'b0; rd = '0;
      while (done < total && budget > 0) begin
         budget--;
         for (int k = 0; k < NM; k++) set_m(k, req[k], req[k], mwe[k], mad[k], mdt[k], msel[k]);
         ack_now    = slv_act && (slv_cnt == slv_dly);
         s_wb_ack_i = ack_now;
         s_wb_dat_i = ack_now ? rd : {$urandom, $urandom};
         smp();
         if (grant_valid_o && !gv_prev) begin
            exp_g = -1;
            for (int i = NM - 1; i >= 0; i--)
               if (work[(exp_ptr + i) % NM] > 0) exp_g = (exp_ptr + i) % NM;
            chk({tag, "_grant_idx"}, 64'(grant_idx_o), 64'(exp_g));
            owner   = exp_g;
            exp_ptr = (exp_g + 1) % NM;
            gcount[grant_idx_o]++;
         end
         gv_prev = grant_valid_o;
         if (ack_now) begin
            onehot = NM'(1) << owner;
            chk({tag, "_ack"},    64'(m_wb_ack_o), 64'(onehot));
            chk({tag, "_rdata"},  m_wb_dat_o, rd);
            chk({tag, "_adr"},    64'(s_wb_adr_o), 64'(mad[owner]));
            chk({tag, "_wdata"},  s_wb_dat_o, mdt[owner]);
            chk({tag, "_sel_we"}, 64'({s_wb_sel_o, s_wb_we_o}), 64'({msel[owner], mwe[owner]}));
            chk({tag, "_err"},    64'(m_wb_err_o), 64'(0));
            work[owner]--; done++;
            req[owner] = 1'b0; cool[owner] = 2;
            slv_act = 1'b0;
         end else if (s_wb_stb_o) begin
            if (!slv_act) begin
               slv_act = 1'b1; slv_cnt = 0;
               slv_dly = $urandom_range(1, 4);
               rd = {$urandom, $urandom};
            end
            slv_cnt++;
         end
         for (int k = 0; k < NM; k++) begin
            if (cool[k] > 0) begin
               cool[k]--;
               if (cool[k] == 0 && work[k] > 0) begin
                  req[k] = 1'b1;
                  mad[k] = $urandom; mdt[k] = {$urandom, $urandom};
                  msel[k] = SW'($urandom); mwe[k] = 1'($urandom);
               end
            end
         end
         tick();
      end
      chk({tag, "_completed"}, 64'(done), 64'(total));
      for (int k = 0; k < NM; k++) chk({tag, "_grant_count"}, 64'(gcount[k]), 64'(init[k]));
      clear_inputs();
      tick();
   endtask

   initial begin
      int w [NM];
      // ---------------- reset state ----------------
      reset = 1'b1;
      clear_inputs();
      #3;
      chk("rst_grant_valid", 64'(grant_valid_o), 64'(0));
      chk("rst_grant_idx",   64'(grant_idx_o),   64'(0));
      chk("rst_s_cyc_stb",   64'({s_wb_cyc_o, s_wb_stb_o}), 64'(0));
      chk("rst_ack_err",     64'({m_wb_ack_o, m_wb_err_o}), 64'(0));
      chk("rst_m_dat",       m_wb_dat_o, 64'(0));
      tick();
      reset = 1'b0;

      // ---------------- single master read ----------------
      set_m(0, 1, 1, 0, 32'h1000_0000, 64'h0, 8'hFF);
      smp(); chk("t1_arb_cycle", 64'(grant_valid_o), 64'(0));
      tick(); smp();
      chk("t1_grant", 64'({grant_valid_o, grant_idx_o}), 64'({1'b1, 2'd0}));
      chk("t1_s_adr", 64'(s_wb_adr_o), 64'h1000_0000);
      chk("t1_s_stb_we", 64'({s_wb_cyc_o, s_wb_stb_o, s_wb_we_o}), 64'(3'b110));
      tick(); smp(); chk("t1_wait1", 64'(m_wb_ack_o), 64'(0));
      tick(); smp(); chk("t1_wait2", 64'(m_wb_ack_o), 64'(0));
      tick(); s_wb_ack_i = 1'b1; s_wb_dat_i = 64'hDEAD_BEEF_0000_0001;
      smp();
      chk("t1_ack", 64'(m_wb_ack_o), 64'(4'b0001));
      chk("t1_rdata", m_wb_dat_o, 64'hDEAD_BEEF_0000_0001);
      tick(); s_wb_ack_i = 1'b0; set_m(0, 0, 0, 0, '0, '0, '0);
      smp(); chk("t1_drop_cyc", 64'(s_wb_cyc_o), 64'(0));
      tick(); smp(); chk("t1_released", 64'(grant_valid_o), 64'(0));

      // ---------------- simultaneous request ----------------
      do_reset();
      set_m(0, 1, 1, 0, 32'hA000_0000, 64'h0, 8'hFF);
      set_m(1, 1, 1, 1, 32'hB000_0000, 64'h1111_2222_3333_4444, 8'h0F);
      smp(); chk("t2_arb_cycle", 64'(grant_valid_o), 64'(0));
      tick(); smp(); chk("t2_first_m0", 64'({grant_valid_o, grant_idx_o}), 64'({1'b1, 2'd0}));
      tick(); s_wb_ack_i = 1'b1; smp(); chk("t2_ack_m0", 64'(m_wb_ack_o), 64'(4'b0001));
      tick(); s_wb_ack_i = 1'b0; m_wb_cyc_i[0] = 1'b0; m_wb_stb_i[0] = 1'b0; smp();
      tick(); m_wb_cyc_i[0] = 1'b1; m_wb_stb_i[0] = 1'b1;
      smp(); chk("t2_idle_gap", 64'(grant_valid_o), 64'(0));
      tick(); smp();
      chk("t2_then_m1", 64'({grant_valid_o, grant_idx_o}), 64'({1'b1, 2'd1}));
      chk("t2_m1_path", 64'({s_wb_adr_o, s_wb_sel_o, s_wb_we_o}), 64'({32'hB000_0000, 8'h0F, 1'b1}));
      chk("t2_m1_wdata", s_wb_dat_o, 64'h1111_2222_3333_4444);
      tick(); s_wb_ack_i = 1'b1; smp(); chk("t2_ack_m1_only", 64'(m_wb_ack_o), 64'(4'b0010));
      tick(); s_wb_ack_i = 1'b0; m_wb_cyc_i[1] = 1'b0; m_wb_stb_i[1] = 1'b0; smp();
      tick(); smp();
      tick(); smp(); chk("t2_m0_again", 64'({grant_valid_o, grant_idx_o}), 64'({1'b1, 2'd0}));
      tick(); s_wb_ack_i = 1'b1; smp();
      tick(); s_wb_ack_i = 1'b0; set_m(0, 0, 0, 0, '0, '0, '0); smp();
      tick(); smp();

      // ---------------- timeout on m1 write, m0 pending ----------------
      tick(); set_m(1, 1, 1, 1, 32'hC000_0000, 64'h5555, 8'hFF); smp();
      for (int i = 1; i <= TMO; i++) begin
         tick();
         if (i == 2) set_m(0, 1, 1, 0, 32'hD000_0000, 64'h0, 8'hFF);
         smp();
         chk("t3_no_early_err", 64'({m_wb_err_o, s_wb_cyc_o}), 64'({4'b0000, 1'b1}));
      end
      tick(); smp();
      chk("t3_err_pulse", 64'(m_wb_err_o), 64'(4'b0010));
      chk("t3_slave_abandoned", 64'({s_wb_cyc_o, s_wb_stb_o}), 64'(0));
      chk("t3_err_dat", m_wb_dat_o, 64'(0));
      tick(); s_wb_ack_i = 1'b1; smp();
      chk("t3_err_once", 64'(m_wb_err_o), 64'(0));
      chk("t3_late_ack_ignored", 64'(m_wb_ack_o), 64'(0));
      tick(); s_wb_ack_i = 1'b0; m_wb_stb_i[1] = 1'b0; smp();
      tick(); m_wb_stb_i[1] = 1'b1; smp(); chk("t3_new_stb_wait", 64'(m_wb_err_o), 64'(0));
      tick(); smp(); chk("t3_new_stb_err", 64'(m_wb_err_o), 64'(4'b0010));
      tick(); smp(); chk("t3_new_stb_once", 64'({m_wb_err_o, s_wb_cyc_o}), 64'(0));
      tick(); set_m(1, 0, 0, 0, '0, '0, '0); smp(); chk("t3_err_hold", 64'(grant_valid_o), 64'(1));
      tick(); smp(); chk("t3_back_idle", 64'(grant_valid_o), 64'(0));
      tick(); smp(); chk("t3_m0_next", 64'({grant_valid_o, grant_idx_o}), 64'({1'b1, 2'd0}));
      tick(); s_wb_ack_i = 1'b1; smp();
      tick(); s_wb_ack_i = 1'b0; set_m(0, 0, 0, 0, '0, '0, '0); smp();
      tick(); smp();

      // ---------------- ack / timeout race on m2 ----------------
      tick(); set_m(2, 1, 1, 0, 32'hE000_0000, 64'h0, 8'hFF); smp();
      for (int i = 1; i < TMO; i++) begin
         tick(); smp();
      end
      tick(); s_wb_ack_i = 1'b1; s_wb_dat_i = 64'h0123_4567_89AB_CDEF; smp();
      chk("t4_race_ack", 64'(m_wb_ack_o), 64'(4'b0100));
      chk("t4_race_rdata", m_wb_dat_o, 64'h0123_4567_89AB_CDEF);
      tick(); s_wb_ack_i = 1'b0; m_wb_stb_i[2] = 1'b0; smp();
      chk("t4_still_own", 64'({m_wb_err_o, grant_valid_o, s_wb_cyc_o}), 64'({4'b0000, 1'b1, 1'b1}));
      for (int i = 1; i <= TMO; i++) begin
         tick();
         if (i == 1) m_wb_stb_i[2] = 1'b1;
         if (i == TMO) s_wb_ack_i = 1'b1;
         smp();
         chk("t4_beat2_no_err", 64'(m_wb_err_o), 64'(0));
      end
      chk("t4_beat2_ack", 64'(m_wb_ack_o), 64'(4'b0100));
      tick(); s_wb_ack_i = 1'b0; set_m(2, 0, 0, 0, '0, '0, '0); smp();
      tick(); smp();

      // ---------------- async reset mid-transaction ----------------
      tick();
      set_m(3, 1, 1, 1, 32'hF000_0000, 64'h77, 8'hFF);
      set_m(1, 1, 1, 0, 32'h1100_0000, 64'h0, 8'hFF);
      smp();
      tick(); smp(); chk("t5_m3_granted", 64'({grant_valid_o, grant_idx_o, s_wb_stb_o}), 64'({1'b1, 2'd3, 1'b1}));
      tick(); #2; s_wb_ack_i = 1'b1; reset = 1'b1; #1;
      chk("t5_async_drop", 64'({s_wb_cyc_o, s_wb_stb_o, grant_valid_o}), 64'(0));
      chk("t5_ack_discard", 64'(m_wb_ack_o), 64'(0));
      tick(); reset = 1'b0; s_wb_ack_i = 1'b0;
      smp(); chk("t5_restart_arb", 64'(grant_valid_o), 64'(0));
      tick(); smp(); chk("t5_ptr_zero", 64'({grant_valid_o, grant_idx_o}), 64'({1'b1, 2'd1}));
      tick(); s_wb_ack_i = 1'b1; smp();
      tick(); clear_inputs(); smp();

      // ---------------- randomized fairness and mixed loads ----------------
      do_reset();
      run_random(10, 10, 10, 10, "fair");
      do_reset();
      for (int k = 0; k < NM; k++) w[k] = $urandom_range(0, 6);
      if (w[0] + w[1] + w[2] + w[3] == 0) w[0] = 1;
      run_random(w[0], w[1], w[2], w[3], "mix");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
